auth_controller: RTL and testbench



---
 rtl/auth_pkg.sv | 16 +
 rtl/auth_password_rom.sv | 10 +
 rtl/auth_controller.sv | 145 ++++++++++++++
 tb/tb_auth_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// auth_pkg: shared state encodings, constants and password table for auth_controller
package auth_pkg;
  typedef enum logic [2:0] {
    ST_ENTER_ID = 3'd0,
    ST_ENTER_PW = 3'd1,
    ST_CHECK    = 3'd2,
    ST_GRANTED  = 3'd3,
    ST_FAIL     = 3'd4,
    ST_LOCKED   = 3'd5
  } auth_state_t;
  localparam logic [3:0] MASTER_DIGIT = 4'hA;
  localparam logic [4:0] PLAYER_NONE = 5'd0;
  function automatic logic [3:0] rom_digit(input logic [3:0] id, input logic [2:0] idx);
    return id + {1'b0, idx} + 4'd1;
  endfunction
endpackage

// File: rtl/auth_password_rom.sv
// auth_password_rom: combinational lookup of the expected password digit for (id, idx)
module auth_password_rom
  import auth_pkg::*;
(
  input  logic [3:0] i_id,
  input  logic [2:0] i_idx,
  output logic [3:0] o_digit
);
  assign o_digit = rom_digit(i_id, i_idx);
endmodule

// File: rtl/auth_controller.sv
// auth_controller: SegmentRunner login FSM with lockout and timeout; AUTH_MASTER_KEY_EN adds a master key
module auth_controller
  import auth_pkg::*;
#(
  parameter int PASS_LEN    = 4,
  parameter int MAX_FAILS   = 3,
  parameter int FAIL_HOLD   = 50_000_000,
  parameter int LOCK_CYCLES = 250_000_000,
  parameter int TIMEOUT     = 500_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] SwPass,
  input  logic       BtPass,
  input  logic [3:0] GameState,
  output logic       LoggedIn,
  output logic [4:0] PlayerID,
  output logic [2:0] AuthState,
  output logic [2:0] DigitIdx,
  output logic [1:0] FailCount,
  output logic       Locked
);
  localparam int HOLD_MAX = FAIL_HOLD > LOCK_CYCLES ? FAIL_HOLD : LOCK_CYCLES;
  localparam int TW = $clog2((HOLD_MAX > TIMEOUT ? HOLD_MAX : TIMEOUT) + 1);
  auth_state_t r_state, w_state_nxt;
  logic [3:0]    r_id, w_id_nxt, w_rom_digit;
  logic          r_mis, w_mis_nxt, w_ok;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_digit_idx, w_idx_nxt;
  logic [1:0]    r_fail_cnt, w_fail_nxt, w_fail_inc;
  logic          r_locked, w_locked_nxt, r_logged_in, w_logged_nxt;
  logic [4:0]    r_player, w_player_nxt;
  auth_password_rom u_rom (.i_id(r_id), .i_idx(r_digit_idx), .o_digit(w_rom_digit));
  assign w_fail_inc = r_fail_cnt + 2'd1;
`ifdef AUTH_MASTER_KEY_EN
  // Cleared by the first digit that is not the master digit, so it survives only an all-master entry.
  logic r_master;
  always_ff @(posedge Clk)
    r_master <= Rst ? 1'b0
              : (r_state == ST_ENTER_ID && BtPass) ? 1'b1
              : (r_state == ST_ENTER_PW && BtPass && SwPass != MASTER_DIGIT) ? 1'b0
              : r_master;
  assign w_ok = !r_mis || r_master;
`else
  assign w_ok = !r_mis;
`endif
  always_comb begin
    w_state_nxt  = r_state;
    w_id_nxt     = r_id;
    w_mis_nxt    = r_mis;
    w_timer_nxt  = r_timer + 1'b1;
    w_idx_nxt    = r_digit_idx;
    w_fail_nxt   = r_fail_cnt;
    w_locked_nxt = r_locked;
    w_logged_nxt = r_logged_in;
    w_player_nxt = r_player;
    case (r_state)
      ST_ENTER_ID: begin
        w_timer_nxt = '0;
        if (BtPass) begin
          w_id_nxt    = SwPass;
          w_mis_nxt   = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_ENTER_PW;
        end
      end
      ST_ENTER_PW: begin
        if (BtPass) begin
          w_mis_nxt   = r_mis | (SwPass != w_rom_digit);
          w_idx_nxt   = r_digit_idx + 3'd1;
          w_timer_nxt = '0;
          w_state_nxt = r_digit_idx == 3'(PASS_LEN - 1) ? ST_CHECK : ST_ENTER_PW;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_nxt = ST_ENTER_ID;
          w_idx_nxt   = '0;
        end
      end
      ST_CHECK: begin
        if (w_ok) begin
          w_state_nxt  = ST_GRANTED;
          w_fail_nxt   = '0;
          w_logged_nxt = 1'b1;
          w_player_nxt = {1'b0, r_id} + 5'd1;
        end else begin
          w_fail_nxt   = w_fail_inc;
          w_locked_nxt = w_fail_inc == 2'(MAX_FAILS);
          w_state_nxt  = w_fail_inc == 2'(MAX_FAILS) ? ST_LOCKED : ST_FAIL;
        end
      end
      ST_GRANTED: begin
        if (BtPass && GameState == 4'd0) begin
          w_state_nxt  = ST_ENTER_ID;
          w_logged_nxt = 1'b0;
          w_player_nxt = PLAYER_NONE;
          w_idx_nxt    = '0;
        end
      end
      ST_FAIL: begin
        if (r_timer == TW'(FAIL_HOLD - 1)) begin
          w_state_nxt = ST_ENTER_ID;
          w_idx_nxt   = '0;
        end
      end
      ST_LOCKED: begin
        if (r_timer == TW'(LOCK_CYCLES - 1)) begin
          w_state_nxt  = ST_ENTER_ID;
          w_idx_nxt    = '0;
          w_fail_nxt   = '0;
          w_locked_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_ENTER_ID;
    endcase
    if (w_state_nxt != r_state) w_timer_nxt = '0;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= ST_ENTER_ID;
      r_id        <= '0;
      r_mis       <= 1'b0;
      r_timer     <= '0;
      r_digit_idx <= '0;
      r_fail_cnt  <= '0;
      r_locked    <= 1'b0;
      r_logged_in <= 1'b0;
      r_player    <= PLAYER_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_mis       <= w_mis_nxt;
      r_timer     <= w_timer_nxt;
      r_digit_idx <= w_idx_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_locked    <= w_locked_nxt;
      r_logged_in <= w_logged_nxt;
      r_player    <= w_player_nxt;
    end
  end
  assign AuthState = r_state;
  assign LoggedIn  = r_logged_in;
  assign PlayerID  = r_player;
  assign DigitIdx  = r_digit_idx;
  assign FailCount = r_fail_cnt;
  assign Locked    = r_locked;
endmodule

// File: tb/tb_auth_controller.sv
// tb_auth_controller: table-driven login attempts scored by a queue, plus timeout/reset sequences
module tb_auth_controller;
  typedef struct packed {
    logic [2:0] st;
    logic       li;
    logic [4:0] pid;
    logic [1:0] fc;
    logic       lk;
  } res_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] digits;
    res_t        r;
  } vec_t;
  logic       Clk = 0, Rst = 1, BtPass = 0;
  logic [3:0] SwPass = 0, GameState = 0;
  logic       LoggedIn, Locked;
  logic [4:0] PlayerID;
  logic [2:0] AuthState, DigitIdx, prev_state = 0;
  logic [1:0] FailCount;
  int checks = 0, failures = 0;
  res_t sb[$];
  vec_t vecs[8];
  auth_controller #(.PASS_LEN(4), .MAX_FAILS(3), .FAIL_HOLD(4), .LOCK_CYCLES(16), .TIMEOUT(32)) dut (
    .Clk(Clk), .Rst(Rst), .SwPass(SwPass), .BtPass(BtPass), .GameState(GameState),
    .LoggedIn(LoggedIn), .PlayerID(PlayerID), .AuthState(AuthState), .DigitIdx(DigitIdx),
    .FailCount(FailCount), .Locked(Locked)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic press(input logic [3:0] d);
    SwPass = d;
    BtPass = 1;
    @(posedge Clk);
    #1;
    BtPass = 0;
  endtask
  task automatic run_vec(input vec_t v);
    press(v.id);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) sb.push_back(v.r);
      press(v.digits[15-4*k -: 4]);
    end
    chk("in_check_state", AuthState, 3'd2);
    chk("in_check_idx", DigitIdx, 3'd4);
    chk("in_check_li", LoggedIn, 1'b0);
    idle(1);
    case (v.r.st)
      3'd3: begin
        GameState = 4'd2;
        press(0);
        chk("busy_logout_li", LoggedIn, 1'b1);
        chk("busy_logout_st", AuthState, 3'd3);
        GameState = 4'd0;
        press(0);
        chk("logout_li", LoggedIn, 1'b0);
        chk("logout_pid", PlayerID, 5'd0);
        chk("logout_st", AuthState, 3'd0);
      end
      3'd4: begin
        press(0);
        idle(2);
        chk("fail_hold_st", AuthState, 3'd4);
        idle(1);
        chk("fail_exit_st", AuthState, 3'd0);
        chk("fail_exit_fc", FailCount, v.r.fc);
      end
      3'd5: begin
        repeat (3) press(0);
        chk("lock_press_st", AuthState, 3'd5);
        chk("lock_press_lk", Locked, 1'b1);
        idle(12);
        chk("lock_hold_st", AuthState, 3'd5);
        idle(1);
        chk("lock_exit_st", AuthState, 3'd0);
        chk("lock_exit_fc", FailCount, 2'd0);
        chk("lock_exit_lk", Locked, 1'b0);
      end
      default: ;
    endcase
  endtask
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge Clk);
      if (!Rst && prev_state == 3'd2 && AuthState != 3'd2) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=empty required=entry st=%0d", AuthState);
        end else begin
          e = sb.pop_front();
          chk("sb_state", AuthState, e.st);
          chk("sb_logged_in", LoggedIn, e.li);
          chk("sb_player_id", PlayerID, e.pid);
          chk("sb_fail_count", FailCount, e.fc);
          chk("sb_locked", Locked, e.lk);
        end
      end
      prev_state = AuthState;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{4'd0, 16'h1234, '{3'd3, 1'b1, 5'd1, 2'd0, 1'b0}};
    vecs[1] = '{4'd3, 16'h0000, '{3'd4, 1'b0, 5'd0, 2'd1, 1'b0}};
    vecs[2] = '{4'd3, 16'h0000, '{3'd4, 1'b0, 5'd0, 2'd2, 1'b0}};
    vecs[3] = '{4'd3, 16'h0000, '{3'd5, 1'b0, 5'd0, 2'd3, 1'b1}};
    vecs[4] = '{4'd15, 16'h0123, '{3'd3, 1'b1, 5'd16, 2'd0, 1'b0}};
`ifdef AUTH_MASTER_KEY_EN
    vecs[5] = '{4'd7, 16'hAAAA, '{3'd3, 1'b1, 5'd8, 2'd0, 1'b0}};
    vecs[6] = '{4'd5, 16'h6780, '{3'd4, 1'b0, 5'd0, 2'd1, 1'b0}};
`else
    vecs[5] = '{4'd7, 16'hAAAA, '{3'd4, 1'b0, 5'd0, 2'd1, 1'b0}};
    vecs[6] = '{4'd5, 16'h6780, '{3'd4, 1'b0, 5'd0, 2'd2, 1'b0}};
`endif
    vecs[7] = '{4'd5, 16'h6789, '{3'd3, 1'b1, 5'd6, 2'd0, 1'b0}};
    idle(2);
    Rst = 0;
    idle(1);
    chk("rst_state", AuthState, 3'd0);
    chk("rst_li", LoggedIn, 1'b0);
    chk("rst_pid", PlayerID, 5'd0);
    chk("rst_idx", DigitIdx, 3'd0);
    chk("rst_fc", FailCount, 2'd0);
    chk("rst_lk", Locked, 1'b0);
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    run_vec('{4'd9, 16'h0000, '{3'd4, 1'b0, 5'd0, 2'd1, 1'b0}});
    press(4'd2);
    press(4'd3);
    press(4'd4);
    idle(31);
    chk("to_pre_st", AuthState, 3'd1);
    chk("to_pre_idx", DigitIdx, 3'd2);
    idle(1);
    chk("to_st", AuthState, 3'd0);
    chk("to_idx", DigitIdx, 3'd0);
    chk("to_fc", FailCount, 2'd1);
    press(4'd2);
    press(4'd3);
    idle(31);
    press(4'd4);
    chk("to_race_st", AuthState, 3'd1);
    chk("to_race_idx", DigitIdx, 3'd2);
    idle(32);
    chk("to_race_exp_st", AuthState, 3'd0);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    Rst = 1;
    idle(1);
    Rst = 0;
    chk("mid_rst_state", AuthState, 3'd0);
    chk("mid_rst_idx", DigitIdx, 3'd0);
    chk("mid_rst_fc", FailCount, 2'd0);
    chk("mid_rst_li", LoggedIn, 1'b0);
    chk("mid_rst_lk", Locked, 1'b0);
    run_vec('{4'd1, 16'h2345, '{3'd3, 1'b1, 5'd2, 2'd0, 1'b0}});
    idle(2);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
